load_store_unit: RTL and testbench

//   Bridges the core's memory stage to the data bus feeding the address decoder and data RAM.
//   - Aligns store data and generates byte enables.
//   - Extracts and sign/zero-extends load data from 32-bit RAM words.
//   - Stalls the core for exactly one cycle per access while the synchronous RAM responds.

---
 rtl/load_store_unit.sv | 137 +++++++++++++
 tb/tb_load_store_unit.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: byte-enable and store-data alignment, load extraction, one-cycle bus stall.
// Optional misalignment trap enabled by defining LSU_MISALIGN_TRAP_EN.
module load_store_unit #(
    parameter int ADDR_W = 32,
    parameter int SIZE_W = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              lsu_req_i,
    input  logic              lsu_we_i,
    input  logic [SIZE_W-1:0] lsu_size_i,
    input  logic [ADDR_W-1:0] lsu_addr_i,
    input  logic [31:0]       lsu_data_i,
    output logic              lsu_stall_req_o,
    output logic [31:0]       lsu_data_o,
    output logic              lsu_misalign_o,
    input  logic [31:0]       data_rdata_i,
    output logic              data_req_o,
    output logic              data_we_o,
    output logic [3:0]        data_be_o,
    output logic [ADDR_W-1:0] data_addr_o,
    output logic [31:0]       data_wdata_o
);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t            r_state;
    logic [1:0]        r_off;
    logic [SIZE_W-1:0] r_size;
    logic              r_we;
    logic [31:0]       r_data;

    logic        w_legal;
    logic        w_misalign;
    logic        w_idle_req;
    logic        w_start;
    logic [1:0]  w_kind;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;

    assign w_kind = lsu_size_i[1:0];

    always_comb begin
        w_legal = 1'b0;
        case (lsu_size_i)
            SIZE_W'(0), SIZE_W'(1), SIZE_W'(2),
            SIZE_W'(4), SIZE_W'(5): w_legal = 1'b1;
            default:                w_legal = 1'b0;
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_misalign = w_legal &&
                        ((w_kind == 2'd1 && lsu_addr_i[0]) ||
                         (w_kind == 2'd2 && lsu_addr_i[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    assign w_idle_req = !rst_i && (r_state == S_IDLE) && lsu_req_i;
    assign w_start    = w_idle_req && w_legal && !w_misalign;

    always_comb begin
        w_be    = 4'b0000;
        w_wdata = lsu_data_i;
        case (w_kind)
            2'd0: begin
                w_be    = 4'b0001 << lsu_addr_i[1:0];
                w_wdata = {4{lsu_data_i[7:0]}};
            end
            2'd1: begin
                w_be    = lsu_addr_i[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{lsu_data_i[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = lsu_data_i;
            end
        endcase
    end

    assign lsu_stall_req_o = w_start;
    assign lsu_misalign_o  = w_idle_req && w_misalign;
    assign data_req_o      = w_start;
    assign data_we_o       = w_start && lsu_we_i;
    assign data_be_o       = w_start ? w_be : 4'b0000;
    assign data_addr_o     = rst_i ? '0 : {lsu_addr_i[ADDR_W-1:2], 2'b00};
    assign data_wdata_o    = rst_i ? '0 : w_wdata;
    assign lsu_data_o      = r_data;

    // Extraction uses the offset/size captured when the request was issued.
    always_comb begin
        w_byte = data_rdata_i[{r_off, 3'b000} +: 8];
        w_half = r_off[1] ? data_rdata_i[31:16] : data_rdata_i[15:0];
        case (r_size)
            SIZE_W'(0): w_load = {{24{w_byte[7]}}, w_byte};
            SIZE_W'(4): w_load = {24'h0, w_byte};
            SIZE_W'(1): w_load = {{16{w_half[15]}}, w_half};
            SIZE_W'(5): w_load = {16'h0, w_half};
            default:    w_load = data_rdata_i;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_off   <= 2'b00;
            r_size  <= '0;
            r_we    <= 1'b0;
            r_data  <= 32'h0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_off   <= lsu_addr_i[1:0];
                        r_size  <= lsu_size_i;
                        r_we    <= lsu_we_i;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!r_we)
                        r_data <= w_load;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed table, hand sequences, random vs byte-array model.
module tb_load_store_unit;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        lsu_req_i;
    logic        lsu_we_i;
    logic [2:0]  lsu_size_i;
    logic [31:0] lsu_addr_i;
    logic [31:0] lsu_data_i;
    logic        lsu_stall_req_o;
    logic [31:0] lsu_data_o;
    logic        lsu_misalign_o;
    logic [31:0] data_rdata_i;
    logic        data_req_o;
    logic        data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_addr_o;
    logic [31:0] data_wdata_o;

    load_store_unit #(.ADDR_W(32), .SIZE_W(3)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i),
        .lsu_size_i(lsu_size_i), .lsu_addr_i(lsu_addr_i),
        .lsu_data_i(lsu_data_i), .lsu_stall_req_o(lsu_stall_req_o),
        .lsu_data_o(lsu_data_o), .lsu_misalign_o(lsu_misalign_o),
        .data_rdata_i(data_rdata_i), .data_req_o(data_req_o),
        .data_we_o(data_we_o), .data_be_o(data_be_o),
        .data_addr_o(data_addr_o), .data_wdata_o(data_wdata_o)
    );

    always #5 clk_i = ~clk_i;

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    // Synchronous RAM seen by the bus (environment, not the reference).
    logic [31:0] ram [0:63];
    always @(posedge clk_i) begin
        if (data_req_o) begin
            data_rdata_i <= ram[data_addr_o[7:2]];
            if (data_we_o)
                for (int b = 0; b < 4; b++)
                    if (data_be_o[b])
                        ram[data_addr_o[7:2]][8*b +: 8] <= data_wdata_o[8*b +: 8];
        end
    end

    // Reference: flat byte memory, little-endian.
    logic [7:0] rb [0:255];
    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] last_load;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic bit is_legal(input logic [2:0] sz);
        return sz == 0 || sz == 1 || sz == 2 || sz == 4 || sz == 5;
    endfunction

    function automatic bit is_mis(input logic [2:0] sz, input logic [31:0] a);
        if (sz == 1 || sz == 5) return a % 2 != 0;
        if (sz == 2) return a % 4 != 0;
        return 1'b0;
    endfunction

    function automatic logic [7:0] eff(input logic [2:0] sz, input logic [31:0] a);
        if (sz == 1 || sz == 5) return a[7:0] & 8'hFE;
        if (sz == 2) return a[7:0] & 8'hFC;
        return a[7:0];
    endfunction

    function automatic logic [3:0] ref_be(input logic [2:0] sz, input logic [31:0] a);
        logic [7:0] e;
        e = eff(sz, a);
        if (sz == 2) return 4'hF;
        if (sz == 1 || sz == 5) return 4'(3 << (e % 4));
        return 4'(1 << (e % 4));
    endfunction

    function automatic logic [31:0] ref_wd(input logic [2:0] sz, input logic [31:0] d);
        if (sz == 2) return d;
        if (sz == 1 || sz == 5) return {16'h0, d[15:0]} * 32'h0001_0001;
        return {24'h0, d[7:0]} * 32'h0101_0101;
    endfunction

    task automatic ref_store(input logic [2:0] sz, input logic [31:0] a, input logic [31:0] d);
        logic [7:0] e;
        int nb;
        e  = eff(sz, a);
        nb = (sz == 2) ? 4 : (sz == 1 || sz == 5) ? 2 : 1;
        for (int i = 0; i < nb; i++)
            rb[8'(e + i)] = d[8*i +: 8];
    endtask

    function automatic logic [31:0] ref_load(input logic [2:0] sz, input logic [31:0] a);
        logic [7:0] e;
        logic [31:0] v;
        e = eff(sz, a);
        if (sz == 2) return {rb[8'(e+3)], rb[8'(e+2)], rb[8'(e+1)], rb[e]};
        if (sz == 1 || sz == 5) begin
            v = {16'h0, rb[8'(e+1)], rb[e]};
            if (sz == 1 && v[15]) v = v - 32'h0001_0000;
            return v;
        end
        v = {24'h0, rb[e]};
        if (sz == 0 && v[7]) v = v - 32'h0000_0100;
        return v;
    endfunction

    // One access starting in IDLE, just after a rising edge.
    task automatic run(input logic we, input logic [2:0] sz, input logic [31:0] a,
                       input logic [31:0] d, input bit go, input bit mis,
                       input logic [3:0] ebe, input logic [31:0] ewd,
                       input logic [31:0] erd);
        lsu_req_i  = 1'b1;
        lsu_we_i   = we;
        lsu_size_i = sz;
        lsu_addr_i = a;
        lsu_data_i = d;
        @(negedge clk_i);
        chk("req", 32'(data_req_o), 32'(go));
        chk("stall", 32'(lsu_stall_req_o), 32'(go));
        chk("misalign", 32'(lsu_misalign_o), 32'(mis));
        chk("be", 32'(data_be_o), go ? 32'(ebe) : 32'h0);
        chk("bus_we", 32'(data_we_o), 32'(go && we));
        if (go) chk("addr", data_addr_o, {a[31:2], 2'b00});
        if (go && we) chk("wdata", data_wdata_o, ewd);
        @(posedge clk_i); #1;
        lsu_req_i = 1'b0;
        if (go) begin
            @(negedge clk_i);
            chk("wait_req", 32'(data_req_o), 32'h0);
            chk("wait_stall", 32'(lsu_stall_req_o), 32'h0);
            chk("wait_be", 32'(data_be_o), 32'h0);
            @(posedge clk_i); #1;
            if (we) ref_store(sz, a, d);
            else last_load = erd;
        end
        chk("ldata", lsu_data_o, (go && !we) ? erd : last_load);
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  sz;
        logic [31:0] a;
        logic [31:0] d;
        bit          go;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] rd;
    } vec_t;

    vec_t tbl[$];

    initial begin
        bit go, mis;
        logic [2:0] sz;
        logic [31:0] a, d, exp0, exp4;
        logic we;

        for (int i = 0; i < 64; i++) ram[i] = 32'h0;
        for (int i = 0; i < 256; i++) rb[i] = 8'h0;
        data_rdata_i = 32'h0;
        last_load    = 32'h0;

        rst_i = 1'b1;
        lsu_req_i = 1'b1; lsu_we_i = 1'b1; lsu_size_i = 3'd2;
        lsu_addr_i = 32'h10; lsu_data_i = 32'hFFFF_FFFF;
        #2;
        chk("rst_req", 32'(data_req_o), 32'h0);
        chk("rst_stall", 32'(lsu_stall_req_o), 32'h0);
        chk("rst_be", 32'(data_be_o), 32'h0);
        chk("rst_wdata", data_wdata_o, 32'h0);
        chk("rst_addr", data_addr_o, 32'h0);
        chk("rst_ldata", lsu_data_o, 32'h0);
        lsu_req_i = 1'b0;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        @(posedge clk_i); #1;

        tbl.push_back('{1, 2, 32'h10, 32'hDEADBEEF, 1, 4'hF, 32'hDEADBEEF, 0});
        tbl.push_back('{0, 2, 32'h10, 0, 1, 4'hF, 0, 32'hDEADBEEF});
        tbl.push_back('{1, 2, 32'h10, 32'h0, 1, 4'hF, 32'h0, 0});
        tbl.push_back('{1, 0, 32'h13, 32'h123456A5, 1, 4'b1000, 32'hA5A5A5A5, 0});
        tbl.push_back('{0, 0, 32'h13, 0, 1, 4'b1000, 0, 32'hFFFFFFA5});
        tbl.push_back('{0, 4, 32'h13, 0, 1, 4'b1000, 0, 32'h000000A5});
        tbl.push_back('{0, 2, 32'h12, 0, 1, 4'hF, 0, 32'hA5000000});
        tbl.push_back('{0, 1, 32'h13, 0, 1, 4'b1100, 0, 32'hFFFFA500});
        tbl.push_back('{1, 2, 32'h0, 32'h80017FFF, 1, 4'hF, 32'h80017FFF, 0});
        tbl.push_back('{0, 1, 32'h2, 0, 1, 4'b1100, 0, 32'hFFFF8001});
        tbl.push_back('{0, 5, 32'h2, 0, 1, 4'b1100, 0, 32'h00008001});
        tbl.push_back('{0, 1, 32'h0, 0, 1, 4'b0011, 0, 32'h00007FFF});
        tbl.push_back('{1, 1, 32'h6, 32'h0000BEEF, 1, 4'b1100, 32'hBEEFBEEF, 0});
        tbl.push_back('{0, 2, 32'h4, 0, 1, 4'hF, 0, 32'hBEEF0000});
        tbl.push_back('{0, 3, 32'h0, 0, 0, 4'h0, 0, 0});
        tbl.push_back('{1, 7, 32'h8, 32'h55, 0, 4'h0, 0, 0});
        tbl.push_back('{0, 4, 32'h0, 0, 1, 4'b0001, 0, 32'h000000FF});
        tbl.push_back('{0, 0, 32'h1, 0, 1, 4'b0010, 0, 32'h0000007F});

        foreach (tbl[i]) begin
            mis = TRAP && tbl[i].go && is_mis(tbl[i].sz, tbl[i].a);
            run(tbl[i].we, tbl[i].sz, tbl[i].a, tbl[i].d, tbl[i].go && !mis, mis,
                tbl[i].be, tbl[i].wd, tbl[i].rd);
        end

        // Back-to-back loads with the request held high.
        exp0 = ref_load(3'd2, 32'h0);
        exp4 = ref_load(3'd2, 32'h4);
        lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_size_i = 3'd2; lsu_addr_i = 32'h0;
        @(negedge clk_i); chk("b2b_stall0", 32'(lsu_stall_req_o), 32'h1);
        @(negedge clk_i); chk("b2b_stall1", 32'(lsu_stall_req_o), 32'h0);
        chk("b2b_req1", 32'(data_req_o), 32'h0);
        @(posedge clk_i); #1;
        chk("b2b_ld0", lsu_data_o, exp0);
        lsu_addr_i = 32'h4;
        @(negedge clk_i); chk("b2b_stall2", 32'(lsu_stall_req_o), 32'h1);
        @(negedge clk_i); chk("b2b_stall3", 32'(lsu_stall_req_o), 32'h0);
        @(posedge clk_i); #1;
        lsu_req_i = 1'b0;
        chk("b2b_ld1", lsu_data_o, exp4);
        last_load = exp4;

        // Reset while a load is waiting drops the load.
        lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_size_i = 3'd2; lsu_addr_i = 32'h10;
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        #1;
        chk("rstw_req", 32'(data_req_o), 32'h0);
        chk("rstw_stall", 32'(lsu_stall_req_o), 32'h0);
        chk("rstw_we", 32'(data_we_o), 32'h0);
        chk("rstw_addr", data_addr_o, 32'h0);
        chk("rstw_ldata", lsu_data_o, 32'h0);
        chk("rstw_mis", 32'(lsu_misalign_o), 32'h0);
        @(posedge clk_i); #1;
        chk("rstw_ldata2", lsu_data_o, 32'h0);
        rst_i = 1'b0;
        last_load = 32'h0;
        @(negedge clk_i);
        chk("rstw_idle_stall", 32'(lsu_stall_req_o), 32'h1);
        @(posedge clk_i); #1;
        lsu_req_i = 1'b0;
        @(posedge clk_i); #1;
        last_load = ref_load(3'd2, 32'h10);
        chk("rstw_reload", lsu_data_o, last_load);

        // Random accesses against the byte-array model.
        for (int it = 0; it < 400; it++) begin
            we = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 9))
                0, 1: sz = 3'd0;
                2, 3: sz = 3'd1;
                4, 5: sz = 3'd2;
                6:    sz = we ? 3'd0 : 3'd4;
                7:    sz = we ? 3'd1 : 3'd5;
                8:    sz = 3'd3;
                default: sz = 3'($urandom_range(6, 7));
            endcase
            a = 32'($urandom_range(0, 255));
            d = $urandom;
            mis = TRAP && is_legal(sz) && is_mis(sz, a);
            go  = is_legal(sz) && !mis;
            run(we, sz, a, d, go, mis, ref_be(sz, a), ref_wd(sz, d),
                ref_load(sz, a));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
